// File: rtl/stopwatch_pkg.sv
// Shared definitions for the BCD stopwatch: controller states, BCD digit
// geometry, count direction encoding and a preload saturation helper.
package stopwatch_pkg;

  localparam int BCD_W = 4;
  localparam logic [BCD_W-1:0] BCD_MAX = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_RUN    = 2'd1,
    ST_PAUSED = 2'd2,
    ST_DONE   = 2'd3
  } sw_state_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // Clamp a raw nibble into the legal decimal range so a bad preload
  // can never leave a non-BCD digit in the counter.
  function automatic logic [BCD_W-1:0] satDigit(input logic [BCD_W-1:0] d);
    return (d > BCD_MAX) ? BCD_MAX : d;
  endfunction

endpackage

// File: rtl/bcd_digit.sv
// One BCD decade of the stopwatch counter. Steps up or down by one when
// enabled and raises carry_o when this step crosses the decade boundary,
// which enables the next more significant digit in the ripple chain.
module bcd_digit
  import stopwatch_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             clear_i,
  input  logic             load_i,
  input  logic [BCD_W-1:0] loadVal_i,
  input  logic             en_i,
  input  dir_e             dir_i,
  output logic [BCD_W-1:0] digit_o,
  output logic             carry_o
);

  logic [BCD_W-1:0] digit_q, digit_d;

  // Carry (up) or borrow (down) leaves this decade only on a real step
  // from its terminal value: 9 when counting up, 0 when counting down.
  always_comb begin
    carry_o = 1'b0;
    if (en_i) begin
      if (dir_i == DIR_UP) carry_o = (digit_q == BCD_MAX);
      else                 carry_o = (digit_q == '0);
    end
  end

  // Next digit value: clear beats load, load beats a count step.
  always_comb begin
    digit_d = digit_q;
    if (clear_i) begin
      digit_d = '0;
    end else if (load_i) begin
      digit_d = satDigit(loadVal_i);
    end else if (en_i) begin
      if (dir_i == DIR_UP) digit_d = (digit_q == BCD_MAX) ? '0 : digit_q + 4'd1;
      else                 digit_d = (digit_q == '0) ? BCD_MAX : digit_q - 4'd1;
    end
  end

  // Digit register.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) digit_q <= '0;
    else         digit_q <= digit_d;
  end

  assign digit_o = digit_q;

endmodule

// File: rtl/stopwatch_bcd.sv
// Multi-digit BCD stopwatch: controller FSM, run-time prescaler, lap
// register and registered status flags around a ripple chain of digits.
module stopwatch_bcd
  import stopwatch_pkg::*;
#(
  parameter int DIGITS   = 2,
  parameter int TICK_DIV = 10
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic                    start_i,
  input  logic                    pause_i,
  input  logic                    clear_i,
  input  logic                    load_i,
  input  logic [BCD_W*DIGITS-1:0] loadVal_i,
  input  logic                    mode_i,
  input  logic                    lap_i,
  output logic [BCD_W*DIGITS-1:0] count_o,
  output logic [BCD_W*DIGITS-1:0] lapVal_o,
  output logic                    running_o,
  output logic                    done_o,
  output logic                    wrap_o
);

  localparam int CW    = BCD_W * DIGITS;
  localparam int PRE_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(TICK_DIV - 1);

  sw_state_e        state_q, state_d;
  dir_e             dir_q, dir_d;
  logic [PRE_W-1:0] pre_q, pre_d;
  logic [CW-1:0]    lapVal_q, lapVal_d;
  logic             running_q, running_d;
  logic             done_q, done_d;
  logic             wrap_q, wrap_d;

  logic             stepEn;
  logic             tick;
  logic [CW-1:0]    countVal;
  logic [DIGITS:0]  digitEn;
  logic             countIsZero;
  logic             countIsOne;

  assign tick        = (pre_q == PRE_LAST);
  assign countIsZero = (countVal == '0);
  assign countIsOne  = (countVal == CW'(1));

  // Controller: clear/load force IDLE, then pause beats start. A down step
  // from 1 lands on 0, so the DONE transition is taken on that same edge.
  always_comb begin
    state_d = state_q;
    dir_d   = dir_q;
    pre_d   = pre_q;
    stepEn  = 1'b0;
    if (clear_i || load_i) begin
      state_d = ST_IDLE;
      pre_d   = '0;
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          if (start_i && !pause_i) begin
            dir_d   = dir_e'(mode_i);
            pre_d   = '0;
            state_d = (mode_i && countIsZero) ? ST_DONE : ST_RUN;
          end
        end
        ST_RUN: begin
          if (pause_i) begin
            state_d = ST_PAUSED;
          end else if (tick) begin
            pre_d  = '0;
            stepEn = 1'b1;
            if (dir_q == DIR_DOWN && countIsOne) state_d = ST_DONE;
          end else begin
            pre_d = pre_q + 1'b1;
          end
        end
        ST_PAUSED: begin
          if (start_i && !pause_i) state_d = ST_RUN;
        end
        ST_DONE: begin
          state_d = ST_DONE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Status flags and lap capture, all computed ahead of the register so
  // every output comes straight from a flop.
  always_comb begin
    running_d = (state_d == ST_RUN);
    done_d    = (state_d == ST_DONE);
    wrap_d    = stepEn && (dir_q == DIR_UP) && digitEn[DIGITS];
    lapVal_d  = lapVal_q;
    if (clear_i)    lapVal_d = '0;
    else if (lap_i) lapVal_d = countVal;
  end

  // Controller, prescaler, lap and flag registers.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q   <= ST_IDLE;
      dir_q     <= DIR_UP;
      pre_q     <= '0;
      lapVal_q  <= '0;
      running_q <= 1'b0;
      done_q    <= 1'b0;
      wrap_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      dir_q     <= dir_d;
      pre_q     <= pre_d;
      lapVal_q  <= lapVal_d;
      running_q <= running_d;
      done_q    <= done_d;
      wrap_q    <= wrap_d;
    end
  end

  assign digitEn[0] = stepEn;

  for (genvar g = 0; g < DIGITS; g++) begin : gDigit
    bcd_digit uDigit (
      .clk_i     (clk_i),
      .rst_ni    (rst_ni),
      .clear_i   (clear_i),
      .load_i    (load_i),
      .loadVal_i (loadVal_i[g*BCD_W +: BCD_W]),
      .en_i      (digitEn[g]),
      .dir_i     (dir_q),
      .digit_o   (countVal[g*BCD_W +: BCD_W]),
      .carry_o   (digitEn[g+1])
    );
  end

  assign count_o   = countVal;
  assign lapVal_o  = lapVal_q;
  assign running_o = running_q;
  assign done_o    = done_q;
  assign wrap_o    = wrap_q;

endmodule

// File: tb/tb_stopwatch_bcd.sv
// Scoreboard bench for stopwatch_bcd: a decimal-integer model of the
// stopwatch predicts every cycle's outputs, and a monitor compares them.
module tb_stopwatch_bcd;

  localparam int DIGITS   = 2;
  localparam int TICK_DIV = 2;
  localparam int CW       = 4 * DIGITS;
  localparam int MAXV     = 99;

  logic          clk_i = 1'b0;
  logic          rst_ni;
  logic          start_i, pause_i, clear_i, load_i, mode_i, lap_i;
  logic [CW-1:0] loadVal_i;
  logic [CW-1:0] count_o, lapVal_o;
  logic          running_o, done_o, wrap_o;

  typedef struct {
    logic [CW-1:0] count;
    logic [CW-1:0] lap;
    logic          running;
    logic          done;
    logic          wrap;
  } exp_t;

  exp_t expQ[$];

  int errors = 0;
  int checks = 0;

  // Reference model state, kept as plain decimal integers and flags.
  int mCount, mLap, mPre;
  bit mRun, mPaused, mDone, mDir;

  stopwatch_bcd #(.DIGITS(DIGITS), .TICK_DIV(TICK_DIV)) dut (
    .clk_i     (clk_i),
    .rst_ni    (rst_ni),
    .start_i   (start_i),
    .pause_i   (pause_i),
    .clear_i   (clear_i),
    .load_i    (load_i),
    .loadVal_i (loadVal_i),
    .mode_i    (mode_i),
    .lap_i     (lap_i),
    .count_o   (count_o),
    .lapVal_o  (lapVal_o),
    .running_o (running_o),
    .done_o    (done_o),
    .wrap_o    (wrap_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic int bcdToIntSat(input logic [CW-1:0] v);
    int r;
    int d;
    r = 0;
    for (int i = DIGITS - 1; i >= 0; i--) begin
      d = int'(v[i*4 +: 4]);
      if (d > 9) d = 9;
      r = r * 10 + d;
    end
    return r;
  endfunction

  function automatic logic [CW-1:0] intToBcd(input int v);
    logic [CW-1:0] r;
    int t;
    r = '0;
    t = v;
    for (int i = 0; i < DIGITS; i++) begin
      r[i*4 +: 4] = 4'(t % 10);
      t = t / 10;
    end
    return r;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("[TB] FAIL %s: actual=%0h required=%0h at %0t", name, act, req, $time);
    end
  endtask

  task automatic modelReset();
    mCount = 0; mLap = 0; mPre = 0;
    mRun = 0; mPaused = 0; mDone = 0; mDir = 0;
  endtask

  // Advance the model by one clock edge and queue what the DUT must show.
  task automatic modelStep(input bit st, input bit pa, input bit cl, input bit ld,
                           input logic [CW-1:0] lv, input bit md, input bit lp);
    int nCount, nPre, nLap;
    bit nRun, nPaused, nDone, nDir, nWrap;
    exp_t e;
    nCount = mCount; nPre = mPre;
    nRun = mRun; nPaused = mPaused; nDone = mDone; nDir = mDir; nWrap = 0;
    nLap = cl ? 0 : (lp ? mCount : mLap);
    if (cl || ld) begin
      nCount = cl ? 0 : bcdToIntSat(lv);
      nPre = 0; nRun = 0; nPaused = 0; nDone = 0;
    end else if (mRun) begin
      if (pa) begin
        nRun = 0; nPaused = 1;
      end else if (mPre == TICK_DIV - 1) begin
        nPre = 0;
        if (!mDir) begin
          if (mCount == MAXV) begin nCount = 0; nWrap = 1; end
          else nCount = mCount + 1;
        end else begin
          nCount = mCount - 1;
          if (nCount == 0) begin nRun = 0; nDone = 1; end
        end
      end else begin
        nPre = mPre + 1;
      end
    end else if (mPaused) begin
      if (st && !pa) begin nPaused = 0; nRun = 1; end
    end else if (!mDone) begin
      if (st && !pa) begin
        nDir = md; nPre = 0;
        if (md && mCount == 0) nDone = 1;
        else nRun = 1;
      end
    end
    mCount = nCount; mPre = nPre; mLap = nLap;
    mRun = nRun; mPaused = nPaused; mDone = nDone; mDir = nDir;
    e.count = intToBcd(nCount);
    e.lap = intToBcd(nLap);
    e.running = nRun;
    e.done = nDone;
    e.wrap = nWrap;
    expQ.push_back(e);
  endtask

  task automatic applyStimulus(input bit st, input bit pa, input bit cl, input bit ld,
                               input logic [CW-1:0] lv, input bit md, input bit lp);
    @(negedge clk_i);
    start_i = st; pause_i = pa; clear_i = cl; load_i = ld;
    loadVal_i = lv; mode_i = md; lap_i = lp;
    modelStep(st, pa, cl, ld, lv, md, lp);
  endtask

  task automatic idleCycles(input int n);
    for (int i = 0; i < n; i++) applyStimulus(0, 0, 0, 0, '0, 0, 0);
  endtask

  task automatic checkAllZero(input string tag);
    checkOutput({tag, ".count"}, 32'(count_o), 32'h0);
    checkOutput({tag, ".lap"}, 32'(lapVal_o), 32'h0);
    checkOutput({tag, ".running"}, 32'(running_o), 32'h0);
    checkOutput({tag, ".done"}, 32'(done_o), 32'h0);
    checkOutput({tag, ".wrap"}, 32'(wrap_o), 32'h0);
  endtask

  // Asynchronous reset in the middle of a cycle; outputs must drop at once.
  task automatic midRunReset();
    @(negedge clk_i);
    start_i = 0; pause_i = 0; clear_i = 0; load_i = 0; lap_i = 0; mode_i = 0;
    #2;
    rst_ni = 1'b0;
    #1;
    checkAllZero("asyncReset");
    modelReset();
    @(negedge clk_i);
    rst_ni = 1'b1;
  endtask

  // Monitor: every cycle the DUT presents a new output set one step after
  // the edge; pop the matching prediction and compare field by field.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk_i);
      #1;
      if (expQ.size() > 0) begin
        e = expQ.pop_front();
        checkOutput("count", 32'(count_o), 32'(e.count));
        checkOutput("lapVal", 32'(lapVal_o), 32'(e.lap));
        checkOutput("running", 32'(running_o), 32'(e.running));
        checkOutput("done", 32'(done_o), 32'(e.done));
        checkOutput("wrap", 32'(wrap_o), 32'(e.wrap));
      end
    end
  end

  initial begin
    rst_ni = 1'b0;
    start_i = 0; pause_i = 0; clear_i = 0; load_i = 0; mode_i = 0; lap_i = 0;
    loadVal_i = '0;
    modelReset();
    #12;
    checkAllZero("reset");
    @(negedge clk_i);
    rst_ni = 1'b1;

    $display("[TB] basic run and asynchronous reset");
    applyStimulus(1, 0, 0, 0, '0, 0, 0);
    idleCycles(25);
    midRunReset();

    $display("[TB] pause and resume");
    applyStimulus(1, 0, 0, 0, '0, 0, 0);
    idleCycles(14);
    for (int i = 0; i < 50; i++) applyStimulus(0, 1, 0, 0, '0, 0, 0);
    applyStimulus(1, 0, 0, 0, '0, 0, 0);
    idleCycles(3);
    for (int i = 0; i < 6; i++) applyStimulus(1, 1, 0, 0, '0, 0, 0);
    applyStimulus(1, 0, 0, 0, '0, 0, 0);
    idleCycles(3);

    $display("[TB] up rollover");
    applyStimulus(0, 0, 0, 1, 8'h98, 0, 0);
    applyStimulus(1, 0, 0, 0, '0, 0, 0);
    idleCycles(8);

    $display("[TB] countdown");
    applyStimulus(0, 0, 0, 1, 8'h03, 0, 0);
    applyStimulus(1, 0, 0, 0, '0, 1, 0);
    idleCycles(10);
    applyStimulus(0, 0, 0, 1, 8'h00, 0, 0);
    applyStimulus(1, 0, 0, 0, '0, 1, 0);
    idleCycles(3);

    $display("[TB] lap and command priority");
    applyStimulus(0, 0, 0, 1, 8'h40, 0, 0);
    applyStimulus(1, 0, 0, 0, '0, 0, 0);
    idleCycles(4);
    applyStimulus(0, 0, 0, 0, '0, 0, 1);
    idleCycles(4);
    applyStimulus(1, 0, 1, 1, 8'h77, 0, 1);
    idleCycles(2);

    $display("[TB] preload saturation");
    applyStimulus(0, 0, 0, 1, 8'hA5, 0, 0);
    idleCycles(2);
    applyStimulus(0, 0, 0, 1, 8'hFF, 0, 0);
    applyStimulus(1, 0, 0, 0, '0, 0, 0);
    idleCycles(6);

    $display("[TB] randomized traffic");
    for (int i = 0; i < 3000; i++) begin
      applyStimulus($urandom_range(0, 3) == 0,
                    $urandom_range(0, 9) == 0,
                    $urandom_range(0, 59) == 0,
                    $urandom_range(0, 29) == 0,
                    CW'($urandom),
                    1'($urandom),
                    $urandom_range(0, 7) == 0);
    end
    start_i = 0; pause_i = 0; clear_i = 0; load_i = 0; lap_i = 0;

    @(negedge clk_i);
    @(negedge clk_i);
    checks++;
    if (expQ.size() != 0) begin
      errors++;
      $display("[TB] FAIL drain: pending=%0d required=0", expQ.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
